control_sequencer: RTL and testbench

Microcoded control unit for the SAP-1 datapath. Steps through fetch and execute T-states and drives one control word per cycle onto the register, ALU, RAM, MAR, PC and output-register enables. Sits beside the instruction register and flag register inside cpu. Takes the current opcode and flags; owns the halt state and idles while the machine is in program mode.

---
 rtl/control_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_control_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : control_sequencer
// Description : Microcoded T-state sequencer for the SAP-1 datapath. Emits one
//               control word per cycle from step, opcode and flags. Owns the
//               sticky halt state and idles in program mode.
// Revision    : 1.0 - initial release
// ============================================================================
module control_sequencer #(
    parameter int FLAG_C_IDX = 0,
    parameter int FLAG_Z_IDX = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pr_mode,
    input  logic [3:0] opcode,
    input  logic [3:0] flags,
    output logic [2:0] step_out,
    output logic       halt,
    output logic       pc_out,
    output logic       pc_inc,
    output logic       pc_jmp,
    output logic       mar_in,
    output logic       ram_in,
    output logic       ram_out,
    output logic       instr_in,
    output logic       instr_out,
    output logic       reg_a_in,
    output logic       reg_a_out,
    output logic       reg_b_in,
    output logic       alu_out,
    output logic       alu_sub,
    output logic       flags_in,
    output logic       out_in
);

    localparam logic [3:0] c_OP_LDA = 4'd1;
    localparam logic [3:0] c_OP_ADD = 4'd2;
    localparam logic [3:0] c_OP_SUB = 4'd3;
    localparam logic [3:0] c_OP_STA = 4'd4;
    localparam logic [3:0] c_OP_LDI = 4'd5;
    localparam logic [3:0] c_OP_JMP = 4'd6;
    localparam logic [3:0] c_OP_JC  = 4'd7;
    localparam logic [3:0] c_OP_JZ  = 4'd8;
    localparam logic [3:0] c_OP_OUT = 4'd14;
    localparam logic [3:0] c_OP_HLT = 4'd15;

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } step_t;

    step_t r_step;
    step_t w_step_next;
    logic  r_halted;
    logic  w_active;
    logic  w_last;
    logic  w_set_halt;
    logic  w_unused_flags;

    // Only the carry and zero bits are consulted.
    assign w_unused_flags = ^flags;

    // The sequencer only drives the datapath when running normally.
    assign w_active = !rst && !pr_mode && !r_halted;
    assign step_out = r_step;
    assign halt     = !rst && (r_halted || w_set_halt);

    // Step register; returns to T0 on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_step <= T0;
        end else begin
            r_step <= w_step_next;
        end
    end

    // Sticky halt flag; cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_halted <= 1'b0;
        end else if (w_set_halt) begin
            r_halted <= 1'b1;
        end
    end

    // Next step: halted freezes, program mode parks at T0, else advance or wrap.
    always_comb begin
        w_step_next = r_step;
        if (r_halted) begin
            w_step_next = r_step;
        end else if (pr_mode) begin
            w_step_next = T0;
        end else if (w_set_halt) begin
            w_step_next = T2;
        end else if (w_last) begin
            w_step_next = T0;
        end else begin
            case (r_step)
                T0:      w_step_next = T1;
                T1:      w_step_next = T2;
                T2:      w_step_next = T3;
                T3:      w_step_next = T4;
                default: w_step_next = T0;
            endcase
        end
    end

    // Control word decode; opcode is live from T2 because the IR loads on the T1 edge.
    always_comb begin
        pc_out     = 1'b0;
        pc_inc     = 1'b0;
        pc_jmp     = 1'b0;
        mar_in     = 1'b0;
        ram_in     = 1'b0;
        ram_out    = 1'b0;
        instr_in   = 1'b0;
        instr_out  = 1'b0;
        reg_a_in   = 1'b0;
        reg_a_out  = 1'b0;
        reg_b_in   = 1'b0;
        alu_out    = 1'b0;
        alu_sub    = 1'b0;
        flags_in   = 1'b0;
        out_in     = 1'b0;
        w_last     = 1'b0;
        w_set_halt = 1'b0;
        if (w_active) begin
            case (r_step)
                T0: begin
                    pc_out = 1'b1;
                    mar_in = 1'b1;
                end
                T1: begin
                    ram_out  = 1'b1;
                    instr_in = 1'b1;
                    pc_inc   = 1'b1;
                end
                T2: begin
                    w_last = 1'b1;
                    case (opcode)
                        c_OP_LDA, c_OP_ADD, c_OP_SUB, c_OP_STA: begin
                            instr_out = 1'b1;
                            mar_in    = 1'b1;
                            w_last    = 1'b0;
                        end
                        c_OP_LDI: begin
                            instr_out = 1'b1;
                            reg_a_in  = 1'b1;
                        end
                        c_OP_JMP: begin
                            instr_out = 1'b1;
                            pc_jmp    = 1'b1;
                        end
                        c_OP_JC: begin
                            instr_out = flags[FLAG_C_IDX];
                            pc_jmp    = flags[FLAG_C_IDX];
                        end
                        c_OP_JZ: begin
                            instr_out = flags[FLAG_Z_IDX];
                            pc_jmp    = flags[FLAG_Z_IDX];
                        end
                        c_OP_OUT: begin
                            reg_a_out = 1'b1;
                            out_in    = 1'b1;
                        end
                        c_OP_HLT: begin
                            w_set_halt = 1'b1;
                        end
                        default: begin
                        end
                    endcase
                end
                T3: begin
                    w_last = 1'b1;
                    case (opcode)
                        c_OP_LDA: begin
                            ram_out  = 1'b1;
                            reg_a_in = 1'b1;
                        end
                        c_OP_STA: begin
                            reg_a_out = 1'b1;
                            ram_in    = 1'b1;
                        end
                        c_OP_ADD, c_OP_SUB: begin
                            ram_out  = 1'b1;
                            reg_b_in = 1'b1;
                            w_last   = 1'b0;
                        end
                        default: begin
                        end
                    endcase
                end
                T4: begin
                    w_last = 1'b1;
                    if (opcode == c_OP_ADD || opcode == c_OP_SUB) begin
                        alu_out  = 1'b1;
                        reg_a_in = 1'b1;
                        flags_in = 1'b1;
                        alu_sub  = (opcode == c_OP_SUB);
                    end
                end
                default: begin
                    w_last = 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_sequencer
// Description : Directed and randomised self-checking bench for the
//               control_sequencer T-state decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_sequencer;

    localparam logic [15:0] PC_OUT    = 16'h8000;
    localparam logic [15:0] PC_INC    = 16'h4000;
    localparam logic [15:0] PC_JMP    = 16'h2000;
    localparam logic [15:0] MAR_IN    = 16'h1000;
    localparam logic [15:0] RAM_IN    = 16'h0800;
    localparam logic [15:0] RAM_OUT   = 16'h0400;
    localparam logic [15:0] INSTR_IN  = 16'h0200;
    localparam logic [15:0] INSTR_OUT = 16'h0100;
    localparam logic [15:0] A_IN      = 16'h0080;
    localparam logic [15:0] A_OUT     = 16'h0040;
    localparam logic [15:0] B_IN      = 16'h0020;
    localparam logic [15:0] ALU_OUT   = 16'h0010;
    localparam logic [15:0] ALU_SUB   = 16'h0008;
    localparam logic [15:0] FLAGS_IN  = 16'h0004;
    localparam logic [15:0] OUT_IN    = 16'h0002;
    localparam logic [15:0] HALT      = 16'h0001;
    localparam logic [15:0] T0P       = PC_OUT | MAR_IN;
    localparam logic [15:0] T1P       = RAM_OUT | INSTR_IN | PC_INC;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pr_mode = 1'b0;
    logic [3:0] opcode = 4'd0;
    logic [3:0] flags = 4'd0;
    logic [2:0] step_out;
    logic halt, pc_out, pc_inc, pc_jmp, mar_in, ram_in, ram_out, instr_in, instr_out;
    logic reg_a_in, reg_a_out, reg_b_in, alu_out, alu_sub, flags_in, out_in;
    logic [15:0] ctrl;

    int checks = 0;
    int failures = 0;

    assign ctrl = {pc_out, pc_inc, pc_jmp, mar_in, ram_in, ram_out, instr_in, instr_out,
                   reg_a_in, reg_a_out, reg_b_in, alu_out, alu_sub, flags_in, out_in, halt};

    control_sequencer #(.FLAG_C_IDX(0), .FLAG_Z_IDX(1)) dut (
        .clk(clk), .rst(rst), .pr_mode(pr_mode), .opcode(opcode), .flags(flags),
        .step_out(step_out), .halt(halt), .pc_out(pc_out), .pc_inc(pc_inc),
        .pc_jmp(pc_jmp), .mar_in(mar_in), .ram_in(ram_in), .ram_out(ram_out),
        .instr_in(instr_in), .instr_out(instr_out), .reg_a_in(reg_a_in),
        .reg_a_out(reg_a_out), .reg_b_in(reg_b_in), .alu_out(alu_out),
        .alu_sub(alu_sub), .flags_in(flags_in), .out_in(out_in)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  op;
        logic [3:0]  fl;
        logic [2:0]  len;
        logic [15:0] c2;
        logic [15:0] c3;
        logic [15:0] c4;
    } vec_t;

    task automatic test_reset();
        opcode = 4'd1;
        @(negedge clk);
        #1;
        checks++;
        if (step_out !== 3'd0) begin
            failures++;
            $display("FAIL reset_step: got %0d want 0", step_out);
        end
        checks++;
        if (ctrl !== 16'h0000) begin
            failures++;
            $display("FAIL reset_ctrl: got %h want 0000", ctrl);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_execute();
        vec_t tbl [14];
        logic [15:0] exp_c;
        tbl = '{
            '{4'd1,  4'd0, 3'd4, INSTR_OUT | MAR_IN, RAM_OUT | A_IN, 16'h0},
            '{4'd2,  4'd0, 3'd5, INSTR_OUT | MAR_IN, RAM_OUT | B_IN, ALU_OUT | A_IN | FLAGS_IN},
            '{4'd3,  4'd0, 3'd5, INSTR_OUT | MAR_IN, RAM_OUT | B_IN, ALU_OUT | A_IN | FLAGS_IN | ALU_SUB},
            '{4'd4,  4'd0, 3'd4, INSTR_OUT | MAR_IN, A_OUT | RAM_IN, 16'h0},
            '{4'd5,  4'd0, 3'd3, INSTR_OUT | A_IN, 16'h0, 16'h0},
            '{4'd6,  4'd0, 3'd3, INSTR_OUT | PC_JMP, 16'h0, 16'h0},
            '{4'd7,  4'd1, 3'd3, INSTR_OUT | PC_JMP, 16'h0, 16'h0},
            '{4'd7,  4'd0, 3'd3, 16'h0, 16'h0, 16'h0},
            '{4'd7,  4'd2, 3'd3, 16'h0, 16'h0, 16'h0},
            '{4'd8,  4'd2, 3'd3, INSTR_OUT | PC_JMP, 16'h0, 16'h0},
            '{4'd8,  4'd1, 3'd3, 16'h0, 16'h0, 16'h0},
            '{4'd14, 4'd0, 3'd3, A_OUT | OUT_IN, 16'h0, 16'h0},
            '{4'd0,  4'hF, 3'd3, 16'h0, 16'h0, 16'h0},
            '{4'd11, 4'hF, 3'd3, 16'h0, 16'h0, 16'h0}
        };
        for (int e = 0; e < 14; e++) begin
            opcode = tbl[e].op;
            flags  = tbl[e].fl;
            for (int s = 0; s < int'(tbl[e].len); s++) begin
                case (s)
                    0:       exp_c = T0P;
                    1:       exp_c = T1P;
                    2:       exp_c = tbl[e].c2;
                    3:       exp_c = tbl[e].c3;
                    default: exp_c = tbl[e].c4;
                endcase
                #1;
                checks++;
                if (step_out !== 3'(s)) begin
                    failures++;
                    $display("FAIL exec_step op=%0d fl=%h: got %0d want %0d", tbl[e].op, tbl[e].fl, step_out, s);
                end
                checks++;
                if (ctrl !== exp_c) begin
                    failures++;
                    $display("FAIL exec_ctrl op=%0d fl=%h T%0d: got %h want %h", tbl[e].op, tbl[e].fl, s, ctrl, exp_c);
                end
                @(negedge clk);
            end
        end
        opcode = 4'd0;
        flags  = 4'd0;
        #1;
        checks++;
        if (step_out !== 3'd0 || ctrl !== T0P) begin
            failures++;
            $display("FAIL exec_wrap: got step %0d ctrl %h want step 0 ctrl %h", step_out, ctrl, T0P);
        end
    endtask

    task automatic test_halt();
        opcode = 4'd15;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (step_out !== 3'd2 || ctrl !== HALT) begin
            failures++;
            $display("FAIL halt_t2: got step %0d ctrl %h want step 2 ctrl %h", step_out, ctrl, HALT);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (step_out !== 3'd2 || ctrl !== HALT) begin
                failures++;
                $display("FAIL halt_hold cyc %0d: got step %0d ctrl %h want step 2 ctrl %h", i, step_out, ctrl, HALT);
            end
        end
        pr_mode = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) pr_mode = 1'b0;
            @(negedge clk);
            #1;
            checks++;
            if (halt !== 1'b1) begin
                failures++;
                $display("FAIL halt_prmode cyc %0d: got %b want 1", i, halt);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (step_out !== 3'd0 || ctrl !== 16'h0000) begin
            failures++;
            $display("FAIL halt_rst: got step %0d ctrl %h want step 0 ctrl 0000", step_out, ctrl);
        end
        @(negedge clk);
        rst = 1'b0;
        opcode = 4'd0;
        #1;
        checks++;
        if (step_out !== 3'd0 || ctrl !== T0P) begin
            failures++;
            $display("FAIL halt_resume: got step %0d ctrl %h want step 0 ctrl %h", step_out, ctrl, T0P);
        end
    endtask

    task automatic test_pr_abort();
        opcode = 4'd2;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (step_out !== 3'd3 || ctrl !== (RAM_OUT | B_IN)) begin
            failures++;
            $display("FAIL abort_t3: got step %0d ctrl %h want step 3 ctrl %h", step_out, ctrl, RAM_OUT | B_IN);
        end
        pr_mode = 1'b1;
        #1;
        checks++;
        if (ctrl !== 16'h0000) begin
            failures++;
            $display("FAIL abort_comb: got %h want 0000", ctrl);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (step_out !== 3'd0 || ctrl !== 16'h0000) begin
                failures++;
                $display("FAIL abort_hold cyc %0d: got step %0d ctrl %h want step 0 ctrl 0000", i, step_out, ctrl);
            end
        end
        @(negedge clk);
        pr_mode = 1'b0;
        opcode = 4'd0;
        #1;
        checks++;
        if (step_out !== 3'd0 || ctrl !== T0P) begin
            failures++;
            $display("FAIL abort_resume: got step %0d ctrl %h want step 0 ctrl %h", step_out, ctrl, T0P);
        end
        @(negedge clk);
        #1;
        checks++;
        if (step_out !== 3'd1 || ctrl !== T1P) begin
            failures++;
            $display("FAIL abort_t1: got step %0d ctrl %h want step 1 ctrl %h", step_out, ctrl, T1P);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        opcode = 4'd2;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (step_out !== 3'd0 || ctrl !== 16'h0000) begin
            failures++;
            $display("FAIL rstmid_async: got step %0d ctrl %h want step 0 ctrl 0000", step_out, ctrl);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (step_out !== 3'd0 || ctrl !== T0P) begin
            failures++;
            $display("FAIL rstmid_t0: got step %0d ctrl %h want step 0 ctrl %h", step_out, ctrl, T0P);
        end
    endtask

    task automatic test_random();
        logic [3:0] cur_op;
        int cnt;
        int want;
        int drivers;
        cur_op = 4'd0;
        cnt = 0;
        for (int c = 0; c < 500; c++) begin
            flags = 4'($urandom);
            if (step_out == 3'd0) begin
                if (cnt > 0) begin
                    case (cur_op)
                        4'd1, 4'd4: want = 4;
                        4'd2, 4'd3: want = 5;
                        default:    want = 3;
                    endcase
                    checks++;
                    if (cnt != want) begin
                        failures++;
                        $display("FAIL rand_len op=%0d: got %0d cycles want %0d", cur_op, cnt, want);
                    end
                end
                cur_op = 4'($urandom_range(0, 14));
                opcode = cur_op;
                cnt = 0;
            end
            #1;
            drivers = int'(pc_out) + int'(ram_out) + int'(instr_out) + int'(reg_a_out) + int'(alu_out);
            checks++;
            if (drivers > 1 || step_out > 3'd4) begin
                failures++;
                $display("FAIL rand_bus cyc %0d: got %0d drivers step %0d want <=1 drivers step <=4", c, drivers, step_out);
            end
            cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_execute();
        test_halt();
        test_pr_abort();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
